// File: rtl/musa_gpio_capture.sv
// -----------------------------------------------------------------------------
// musa_gpio_capture
//
// Capture buffer for MUSA processor GPIO writes. Every rising edge of the
// processor GPIO write strobe pushes the GPIO word present in that cycle into
// a small FIFO. A host-side reader drains the FIFO over a valid/ready
// handshake. The read port is first-word-fall-through.
//
// Optional feature (macro GPIO_CAPTURE_DEDUP_EN): an event whose data equals
// the last non-suppressed event's data is suppressed (no push, no overflow).
//
// Parameters:
//   DATA_WIDTH  GPIO word width
//   DEPTH       FIFO entries (power of two, >= 2)
//   ADDR_W      pointer width, derived from DEPTH
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   gpio_i      processor GPIO data
//   we_gpio_i   processor GPIO write strobe (level, may be long)
//   clear_i     synchronous flush of contents, pointers and overflow flag
//   rd_data_o   head-of-FIFO word
//   rd_valid_o  rd_data_o holds an unread word
//   rd_ready_i  reader accepts the head word
//   count_o     number of stored words, 0..DEPTH
//   overflow_o  sticky: a capture was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module musa_gpio_capture #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 8,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] gpio_i,
    input  logic                  we_gpio_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ADDR_W:0]       count_o,
    output logic                  overflow_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count_q;
    logic [ADDR_W:0]       count_d;
    logic                  we_q;
    logic                  overflow_q;

    logic                  evt;
    logic                  cand;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // we_q resets high so a strobe already asserted at reset release is not
    // mistaken for a fresh rising edge.
    assign evt  = we_gpio_i & ~we_q;
    assign full = (count_q == FULL_CNT);
    assign pop  = rd_valid_o & rd_ready_i;

`ifdef GPIO_CAPTURE_DEDUP_EN
    logic [DATA_WIDTH-1:0] last_val;
    logic                  last_vld;
    logic                  dup;

    assign dup  = last_vld && (gpio_i == last_val);
    assign cand = evt & ~dup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld <= 1'b0;
        end else if (clear_i) begin
            last_vld <= 1'b0;
        end else if (cand) begin
            last_vld <= 1'b1;
        end
    end

    // Loaded for every non-suppressed event, including ones dropped on
    // overflow, so a repeat of a dropped word is also suppressed.
    always_ff @(posedge clk) begin
        if (cand && !clear_i) begin
            last_val <= gpio_i;
        end
    end
`else
    assign cand = evt;
`endif

    // When full, a same-cycle pop frees the slot the push needs.
    assign push = cand & (~full | pop);
    assign drop = cand & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            we_q <= we_gpio_i;
            if (clear_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
                if (drop) overflow_q <= 1'b1;
                count_q <= count_d;
            end
        end
    end

    // Storage is not reset; its contents are unobservable while count is 0.
    always_ff @(posedge clk) begin
        if (push && !clear_i) begin
            mem[wr_ptr] <= gpio_i;
        end
    end

    assign rd_data_o  = mem[rd_ptr];
    assign rd_valid_o = (count_q != '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_musa_gpio_capture.sv
module tb_musa_gpio_capture;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] gpio_i;
    logic          we_gpio_i;
    logic          clear_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [AW:0]   count_o;
    logic          overflow_o;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    musa_gpio_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gpio_i     (gpio_i),
        .we_gpio_i  (we_gpio_i),
        .clear_i    (clear_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // One strobe: high for hi cycles, then one low cycle.
    task automatic strobe(input logic [DW-1:0] d, input int hi);
        gpio_i    = d;
        we_gpio_i = 1'b1;
        repeat (hi) tick();
        we_gpio_i = 1'b0;
        tick();
    endtask

    // Pop n words, comparing each against the scoreboard head.
    task automatic drain(input int n, input string name);
        logic [DW-1:0] e;
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            vectors++;
            if (rd_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_valid[%0d]: got %b required 1", name, i, rd_valid_o);
            end
            vectors++;
            if (rd_data_o !== e) begin
                miscompares++;
                $display("FAIL %s_data[%0d]: got %h required %h", name, i, rd_data_o, e);
            end
            rd_ready_i = 1'b1;
            tick();
            rd_ready_i = 1'b0;
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gpio_i = '0; we_gpio_i = 1'b0; clear_i = 1'b0; rd_ready_i = 1'b0;
        repeat (3) tick();
        chk("reset_valid", {31'b0, rd_valid_o}, 0);
        chk("reset_count", {28'b0, count_o}, 0);
        chk("reset_overflow", {31'b0, overflow_o}, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        gpio_i = 32'hA5A5_0001; we_gpio_i = 1'b1;
        exp_q.push_back(32'hA5A5_0001);
        tick();
        chk("basic_count", {28'b0, count_o}, 1);
        chk("basic_valid", {31'b0, rd_valid_o}, 1);
        chk("basic_data", rd_data_o, 32'hA5A5_0001);
        repeat (9) tick();
        chk("basic_long_strobe_count", {28'b0, count_o}, 1);
        we_gpio_i = 1'b0;
        tick();
        drain(1, "basic_drain");
        chk("basic_empty", {31'b0, rd_valid_o}, 0);
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 9; i++) begin
            if (i <= DEPTH) exp_q.push_back(DW'(i));
            strobe(DW'(i), 1);
        end
        chk("fill_count", {28'b0, count_o}, DEPTH);
        chk("fill_overflow", {31'b0, overflow_o}, 1);
        drain(DEPTH, "fill_drain");
        chk("fill_empty", {31'b0, rd_valid_o}, 0);
        chk("fill_overflow_sticky", {31'b0, overflow_o}, 1);
        do_clear();
        chk("fill_overflow_cleared", {31'b0, overflow_o}, 0);
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= DEPTH; i++) begin
            exp_q.push_back(DW'(i));
            strobe(DW'(i), 1);
        end
        chk("fullpop_head", rd_data_o, exp_q.pop_front());
        gpio_i = 32'h55; we_gpio_i = 1'b1; rd_ready_i = 1'b1;
        exp_q.push_back(32'h55);
        tick();
        we_gpio_i = 1'b0; rd_ready_i = 1'b0;
        tick();
        chk("fullpop_count", {28'b0, count_o}, DEPTH);
        chk("fullpop_overflow", {31'b0, overflow_o}, 0);
        drain(DEPTH, "fullpop_drain");
        chk("fullpop_empty", {31'b0, rd_valid_o}, 0);
    endtask

    task automatic test_clear();
        strobe(32'h11, 1); strobe(32'h22, 1); strobe(32'h33, 1);
        chk("clear_pre_count", {28'b0, count_o}, 3);
        gpio_i = 32'h44; we_gpio_i = 1'b1; clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clear_count", {28'b0, count_o}, 0);
        chk("clear_valid", {31'b0, rd_valid_o}, 0);
        tick();
        chk("clear_strobe_lost", {28'b0, count_o}, 0);
        we_gpio_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        for (int i = 1; i <= 9; i++) strobe(DW'(i + 32'h100), 1);
        chk("rstmid_pre_overflow", {31'b0, overflow_o}, 1);
        gpio_i = 32'h99; we_gpio_i = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_count", {28'b0, count_o}, 0);
        chk("rstmid_valid", {31'b0, rd_valid_o}, 0);
        chk("rstmid_overflow", {31'b0, overflow_o}, 0);
        tick(); tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("rstmid_held_strobe", {28'b0, count_o}, 0);
        we_gpio_i = 1'b0;
        tick();
    endtask

    task automatic test_dedup();
        logic [DW-1:0] seq [4];
        seq = '{32'd7, 32'd7, 32'd8, 32'd7};
        for (int i = 0; i < 4; i++) begin
`ifdef GPIO_CAPTURE_DEDUP_EN
            if (i != 1) exp_q.push_back(seq[i]);
`else
            exp_q.push_back(seq[i]);
`endif
            strobe(seq[i], 2);
        end
`ifdef GPIO_CAPTURE_DEDUP_EN
        chk("dedup_count", {28'b0, count_o}, 3);
        drain(3, "dedup_drain");
`else
        chk("dedup_count", {28'b0, count_o}, 4);
        drain(4, "dedup_drain");
`endif
        chk("dedup_empty", {31'b0, rd_valid_o}, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_pop();
        test_clear();
        test_reset_midop();
        test_dedup();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/musa_gpio_capture.md
# musa_gpio_capture

Capture buffer for MUSA processor GPIO writes. Sits beside the processor top and detects each rising edge of the processor write strobe `we_gpio`. It stores the `gpio_o` word present at that edge in a small FIFO and presents the stored words to a host-side reader (bench monitor, debug UART) over a valid/ready handshake. It is the consuming end of the processor's GPIO output interface.

## Interface
- `DATA_WIDTH`, 32: GPIO word width; matches the processor `DATA_WIDTH`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width (derived; not overridden).
- `clk` in 1: single clock. All inputs are synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `gpio_i` in DATA_WIDTH: processor GPIO data (`gpio_o` of top).
- `we_gpio_i` in 1: processor GPIO write strobe. It is level and may stay high for many `clk` cycles.
- `clear_i` in 1: synchronous flush.
- `rd_data_o` out DATA_WIDTH: head-of-FIFO word.
- `rd_valid_o` out 1: `rd_data_o` holds an unread word.
- `rd_ready_i` in 1: reader accepts the head word.
- `count_o` out ADDR_W+1: number of stored words, 0..DEPTH.
- `overflow_o` out 1: sticky; a capture was dropped because the FIFO was full.

## Operation
- Edge detect: `we_q` is a register of `we_gpio_i`. A capture event is `we_gpio_i & ~we_q`.
  - Exactly one event per strobe, regardless of strobe length.
  - A strobe already high when reset is released gives no event, because `we_q` resets to 1.
- Push: on an event, `gpio_i` sampled in that same cycle is written at `wr_ptr`.
- Pop: occurs when `rd_valid_o & rd_ready_i`. `rd_ptr` advances.
- Read port is first-word-fall-through:
  - `rd_data_o = mem[rd_ptr]`.
  - `rd_valid_o = (count != 0)`.
- Pointers are ADDR_W bits and wrap naturally modulo DEPTH. `count` is tracked explicitly.
- Full (count==DEPTH), event, no pop in the same cycle: word is dropped, `overflow_o` sets, count is unchanged.
- Full, event and pop in the same cycle: push is accepted and count stays DEPTH.
- Empty, event and `rd_ready_i` high in the same cycle: no pop, because `rd_valid_o` is 0. The word becomes visible next cycle.
- Push and pop in the same cycle (non-full, non-empty): count is unchanged.
- `clear_i`:
  - Effects: count, both pointers, `overflow_o` and the dedup state go to 0.
  - Priority over push and pop in the same cycle, and any event in that cycle is discarded.
  - `we_q` still updates.
- `overflow_o` clears only by `clear_i` or reset.
- Reset mid-operation discards all contents. The memory array itself is not reset, and its contents are invisible while count==0.

## Timing
- Reset values:
  - `rd_valid_o`=0, `count_o`=0, `overflow_o`=0.
  - `rd_data_o` is don't-care (mem is not reset).
  - Internal: `we_q`=1, pointers 0.
- Capture latency: event in cycle N → `rd_valid_o`/`count_o` updated after edge N+1. The word is readable in cycle N+1.
- Pop: handshake in cycle N → next word (or `rd_valid_o`=0) in cycle N+1.
- `overflow_o` asserts in the cycle after the dropped event.
- Minimum strobe spacing: one low cycle between strobes. Back-to-back strobes at every other cycle are all captured.

## Configuration
- `GPIO_CAPTURE_DEDUP_EN` defined:
  - Registers `last_val` and `last_vld` are added.
  - An event whose `gpio_i` equals `last_val` while `last_vld`=1 is suppressed: no push and no overflow.
  - Every non-suppressed event loads `last_val`=`gpio_i` and sets `last_vld`=1, including events dropped for overflow.
  - `clear_i` and reset clear `last_vld`.
- `GPIO_CAPTURE_DEDUP_EN` undefined: every event is a capture candidate and the dedup registers do not exist.

## Test plan
- Basic capture:
  - Stimulus: `rd_ready_i`=0. Strobe `we_gpio_i` high for 10 cycles with `gpio_i`=0xA5A5_0001, then low.
  - Required: `count_o`=1, `rd_data_o`=0xA5A5_0001, `rd_valid_o`=1 one cycle after the rising edge.
- Fill, overflow and drain:
  - Stimulus: 9 strobes with data 1..9, `rd_ready_i`=0 (DEPTH=8).
  - Required: `count_o`=8, `overflow_o`=1. Then with `rd_ready_i`=1, reads return 1..8 in order. `rd_valid_o`=0 after the 8th read. `overflow_o` stays 1 until `clear_i`.
- Full with simultaneous pop:
  - Stimulus: FIFO full (1..8). Strobe data 0x55 in the same cycle as a pop.
  - Required: `count_o` stays 8, `overflow_o`=0, drain yields 2..8, 0x55.
- Clear and reset mid-operation:
  - Stimulus: 3 words stored, then `clear_i` asserted in the same cycle as a strobe.
  - Required: `count_o`=0, `rd_valid_o`=0 next cycle, and the strobe word is lost.
  - Stimulus: `rst_n` asserted low asynchronously with `we_gpio_i` held high, then released.
  - Required: outputs are 0 immediately on assertion. The held strobe gives no capture after release.
- Dedup:
  - Build: `GPIO_CAPTURE_DEDUP_EN` defined.
  - Stimulus: strobes with data 7, 7, 8, 7.
  - Required: `count_o`=3, reads 7, 8, 7.
  - Build: macro undefined, same stimulus.
  - Required: `count_o`=4, reads 7, 7, 8, 7.
